// File: rtl/rf_writeback_if.sv
// rf_writeback_if: bundles the ALU result handshake, load issue/return,
// decode hazard query and RF write port of the register-file writeback block.
`timescale 1ns/1ps
interface rf_writeback_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    // ALU result producer
    logic              AluValid;
    logic [ADDR_W-1:0] AluReg;
    logic [DATA_W-1:0] AluData;
    logic              AluReady;
    // Load issue and out-of-order load return
    logic              LoadIssue;
    logic [ADDR_W-1:0] LoadIssueReg;
    logic              LoadValid;
    logic [ADDR_W-1:0] LoadReg;
    logic [DATA_W-1:0] LoadData;
    // Decode hazard query
    logic [ADDR_W-1:0] QueryReg1;
    logic [ADDR_W-1:0] QueryReg2;
    logic              Busy1;
    logic              Busy2;
    // Register file write port
    logic              RegWre;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;

    // Writeback block side
    modport slave (
        input  AluValid, AluReg, AluData,
        input  LoadIssue, LoadIssueReg, LoadValid, LoadReg, LoadData,
        input  QueryReg1, QueryReg2,
        output AluReady, Busy1, Busy2,
        output RegWre, WriteReg, WriteData
    );

    // Pipeline / environment side
    modport master (
        output AluValid, AluReg, AluData,
        output LoadIssue, LoadIssueReg, LoadValid, LoadReg, LoadData,
        output QueryReg1, QueryReg2,
        input  AluReady, Busy1, Busy2,
        input  RegWre, WriteReg, WriteData
    );
endinterface

// File: rtl/rf_writeback.sv
// rf_writeback: merges buffered ALU results and out-of-order load returns
// onto the single register-file write port, and tracks outstanding writes
// (pending loads, queued ALU results, the in-flight RF write) for decode.
`timescale 1ns/1ps
module rf_writeback #(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32
) (
    input  logic           clk,
    input  logic           Reset,
    rf_writeback_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // ALU result buffer
    logic [ADDR_W-1:0] fifo_reg  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;

    // Destinations of issued loads whose data has not yet returned
    logic [NREG-1:0]   pending, pending_next;

    logic              alu_xfer, alu_live, load_live, fifo_empty;
    logic              push, pop, emit;
    logic [ADDR_W-1:0] emit_reg;
    logic [DATA_W-1:0] emit_data;
    logic [PTR_W-1:0]  slot_off;
    logic              hit1, hit2;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign bus.AluReady = (count < CNT_MAX);
    assign alu_xfer     = bus.AluValid && bus.AluReady;
    // Writes to register 0 are accepted but otherwise vanish.
    assign alu_live     = alu_xfer && (bus.AluReg != '0);
    assign load_live    = bus.LoadValid && (bus.LoadReg != '0);
    assign fifo_empty   = (count == '0);

    // Pick the write source: load return, then oldest buffered ALU result, then ALU bypass.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        push      = 1'b0;
        pop       = 1'b0;
        emit      = 1'b0;
        emit_reg  = '0;
        emit_data = '0;
        if (load_live) begin
            emit      = 1'b1;
            emit_reg  = bus.LoadReg;
            emit_data = bus.LoadData;
            push      = alu_live;
        end else if (!fifo_empty) begin
            pop       = 1'b1;
            emit      = 1'b1;
            emit_reg  = fifo_reg[rd_ptr];
            emit_data = fifo_data[rd_ptr];
            push      = alu_live;
        end else if (alu_live) begin
            emit      = 1'b1;
            emit_reg  = bus.AluReg;
            emit_data = bus.AluData;
        end
    end

    // Scoreboard update: a return clears, an issue sets, and the set wins on a same-cycle collision.
    always_comb begin
        pending_next = pending;
        if (bus.LoadValid)
            pending_next[bus.LoadReg] = 1'b0;
        if (bus.LoadIssue && (bus.LoadIssueReg != '0))
            pending_next[bus.LoadIssueReg] = 1'b1;
    end

    // Hazard lookup: pending load, any occupied buffer slot, or the RF write in flight.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        slot_off = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            // Distance from the head; slots closer than count are occupied.
            slot_off = PTR_W'(i) - rd_ptr;
            if ({1'b0, slot_off} < count) begin
                if (fifo_reg[i] == bus.QueryReg1) hit1 = 1'b1;
                if (fifo_reg[i] == bus.QueryReg2) hit2 = 1'b1;
            end
        end
        bus.Busy1 = (bus.QueryReg1 != '0) &&
                    (pending[bus.QueryReg1] || hit1 ||
                     (bus.RegWre && (bus.WriteReg == bus.QueryReg1)));
        bus.Busy2 = (bus.QueryReg2 != '0) &&
                    (pending[bus.QueryReg2] || hit2 ||
                     (bus.RegWre && (bus.WriteReg == bus.QueryReg2)));
    end

    // Buffer storage writes at the tail.
    // NOTE: the storage array has no reset; occupancy is defined by count and pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= bus.AluReg;
            fifo_data[wr_ptr] <= bus.AluData;
        end
    end

    // Pointers, occupancy, scoreboard and the registered RF write port.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            pending       <= '0;
            bus.RegWre    <= 1'b0;
            bus.WriteReg  <= '0;
            bus.WriteData <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            pending    <= pending_next;
            bus.RegWre <= emit;
            if (emit) begin
                bus.WriteReg  <= emit_reg;
                bus.WriteData <= emit_data;
            end
        end
    end
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed table of writeback scenarios with hand-derived
// expectations, an asynchronous reset sequence, then random traffic checked
// against a queue-based reference model of the writeback rules.
`timescale 1ns/1ps
module tb_rf_writeback;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_writeback_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    rf_writeback #(.FIFO_DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus row plus the values it must produce.
    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_r;
        logic [31:0] alu_d;
        logic        li;
        logic [4:0]  li_r;
        logic        lv;
        logic [4:0]  lv_r;
        logic [31:0] lv_d;
        logic [4:0]  q1, q2;
        logic        e_rdy, e_b1, e_b2, e_wre;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(input int alu_v, input int alu_r, input int alu_d,
                                input int li, input int li_r,
                                input int lv, input int lv_r, input int lv_d,
                                input int q1, input int q2,
                                input int e_rdy, input int e_b1, input int e_b2,
                                input int e_wre, input int e_reg, input int e_data);
        vec_t r;
        r.alu_v = 1'(alu_v);  r.alu_r = 5'(alu_r);  r.alu_d = 32'(alu_d);
        r.li    = 1'(li);     r.li_r  = 5'(li_r);
        r.lv    = 1'(lv);     r.lv_r  = 5'(lv_r);   r.lv_d  = 32'(lv_d);
        r.q1    = 5'(q1);     r.q2    = 5'(q2);
        r.e_rdy = 1'(e_rdy);  r.e_b1  = 1'(e_b1);   r.e_b2  = 1'(e_b2);
        r.e_wre = 1'(e_wre);  r.e_reg = 5'(e_reg);  r.e_data = 32'(e_data);
        return r;
    endfunction

    // Reference model: ALU results in acceptance order, pending bits, last write.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;
    ent_t        mq[$];
    bit          mpend[32];
    bit          m_wre;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    task automatic model_reset();
        mq.delete();
        foreach (mpend[i]) mpend[i] = 1'b0;
        m_wre  = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endtask

    function automatic bit model_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit model_busy(input logic [4:0] q);
        if (q == 0) return 1'b0;
        if (mpend[q]) return 1'b1;
        foreach (mq[i]) if (mq[i].r == q) return 1'b1;
        return m_wre && (m_reg == q);
    endfunction

    // Applies one clock edge of the writeback rules to the model.
    task automatic model_step();
        bit   alu_ok;
        ent_t e;
        alu_ok = bus.AluValid && model_ready() && (bus.AluReg != 0);
        e.r = bus.AluReg;
        e.d = bus.AluData;
        if (bus.LoadValid && bus.LoadReg != 0) begin
            m_wre = 1'b1; m_reg = bus.LoadReg; m_data = bus.LoadData;
            if (alu_ok) mq.push_back(e);
        end else if (mq.size() > 0) begin
            ent_t h;
            h = mq.pop_front();
            m_wre = 1'b1; m_reg = h.r; m_data = h.d;
            if (alu_ok) mq.push_back(e);
        end else if (alu_ok) begin
            m_wre = 1'b1; m_reg = e.r; m_data = e.d;
        end else begin
            m_wre = 1'b0;
        end
        if (bus.LoadValid) mpend[bus.LoadReg] = 1'b0;
        if (bus.LoadIssue && bus.LoadIssueReg != 0) mpend[bus.LoadIssueReg] = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        bus.AluValid     = v.alu_v;
        bus.AluReg       = v.alu_r;
        bus.AluData      = v.alu_d;
        bus.LoadIssue    = v.li;
        bus.LoadIssueReg = v.li_r;
        bus.LoadValid    = v.lv;
        bus.LoadReg      = v.lv_r;
        bus.LoadData     = v.lv_d;
        bus.QueryReg1    = v.q1;
        bus.QueryReg2    = v.q2;
    endtask

    // Drive at the falling edge, check combinational outputs, clock, check registered outputs.
    task automatic run_cycle(input vec_t v, input bit use_table);
        @(negedge clk);
        drive(v);
        #1;
        if (use_table) begin
            check("ready", 32'(bus.AluReady), 32'(v.e_rdy));
            check("busy1", 32'(bus.Busy1), 32'(v.e_b1));
            check("busy2", 32'(bus.Busy2), 32'(v.e_b2));
        end else begin
            check("m_ready", 32'(bus.AluReady), 32'(model_ready()));
            check("m_busy1", 32'(bus.Busy1), 32'(model_busy(v.q1)));
            check("m_busy2", 32'(bus.Busy2), 32'(model_busy(v.q2)));
        end
        @(posedge clk);
        model_step();
        #1;
        if (use_table) begin
            check("regwre", 32'(bus.RegWre), 32'(v.e_wre));
            if (v.e_wre) begin
                check("writereg", 32'(bus.WriteReg), 32'(v.e_reg));
                check("writedata", bus.WriteData, v.e_data);
            end
        end else begin
            check("m_regwre", 32'(bus.RegWre), 32'(m_wre));
            check("m_writereg", 32'(bus.WriteReg), 32'(m_reg));
            check("m_writedata", bus.WriteData, m_data);
        end
    endtask

    vec_t tbl[$];
    vec_t idle;

    initial begin
        idle = mk(0,0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,0,0);
        drive(idle);
        model_reset();

        // Directed rows: alu_v,alu_r,alu_d, li,li_r, lv,lv_r,lv_d, q1,q2, rdy,b1,b2, wre,reg,data
        // ALU bypass into an empty buffer
        tbl.push_back(mk(1,3,'h11, 0,0, 0,0,0,    3,0,  1,0,0, 1,3,'h11));
        tbl.push_back(mk(0,0,0,    0,0, 0,0,0,    3,0,  1,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,    0,0, 0,0,0,    3,0,  1,0,0, 0,0,0));
        // Load and ALU collide: load first, ALU one cycle later
        tbl.push_back(mk(1,6,'hBB, 0,0, 1,5,'hAA, 5,6,  1,0,0, 1,5,'hAA));
        tbl.push_back(mk(0,0,0,    0,0, 0,0,0,    5,6,  1,1,1, 1,6,'hBB));
        tbl.push_back(mk(0,0,0,    0,0, 0,0,0,    6,5,  1,1,0, 0,0,0));
        // Four load returns while r7,r8,r9 wait; buffer fills after two accepts
        tbl.push_back(mk(1,7,'h77, 0,0, 1,11,'hA1, 7,0, 1,0,0, 1,11,'hA1));
        tbl.push_back(mk(1,8,'h88, 0,0, 1,12,'hA2, 7,8, 1,1,0, 1,12,'hA2));
        tbl.push_back(mk(1,9,'h99, 0,0, 1,13,'hA3, 8,9, 0,1,0, 1,13,'hA3));
        tbl.push_back(mk(1,9,'h99, 0,0, 1,14,'hA4, 7,9, 0,1,0, 1,14,'hA4));
        tbl.push_back(mk(1,9,'h99, 0,0, 0,0,0,     9,7, 0,0,1, 1,7,'h77));
        tbl.push_back(mk(1,9,'h99, 0,0, 0,0,0,     9,8, 1,0,1, 1,8,'h88));
        tbl.push_back(mk(0,0,0,    0,0, 0,0,0,     9,0, 1,1,0, 1,9,'h99));
        tbl.push_back(mk(0,0,0,    0,0, 0,0,0,     9,0, 1,1,0, 0,0,0));
        // Scoreboard: issue r10, return r10, busy through the write cycle
        tbl.push_back(mk(0,0,0,    1,10, 0,0,0,      10,0, 1,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,    0,0,  0,0,0,      10,0, 1,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,    0,0,  1,10,'h1010, 10,0, 1,1,0, 1,10,'h1010));
        tbl.push_back(mk(0,0,0,    0,0,  0,0,0,      10,0, 1,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,    0,0,  0,0,0,      10,0, 1,0,0, 0,0,0));
        // Register 0 is dropped from every source
        tbl.push_back(mk(1,0,'h55, 0,0, 0,0,0,    0,0, 1,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,    1,0, 1,0,'h66, 0,0, 1,0,0, 0,0,0));
        // Same-cycle issue and return of r4: written, and still pending afterwards
        tbl.push_back(mk(0,0,0,    1,4, 1,4,'h44, 4,0, 1,0,0, 1,4,'h44));
        tbl.push_back(mk(0,0,0,    0,0, 0,0,0,    4,0, 1,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,    0,0, 0,0,0,    4,0, 1,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,    0,0, 1,4,'h45, 4,0, 1,1,0, 1,4,'h45));
        tbl.push_back(mk(0,0,0,    0,0, 0,0,0,    4,0, 1,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,    0,0, 0,0,0,    4,0, 1,0,0, 0,0,0));

        // Reset values, with active inputs that must be ignored
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(mk(1,3,'h33, 1,3, 1,2,'h22, 2,3, 0,0,0, 0,0,0));
        @(posedge clk);
        #1;
        check("rst_regwre", 32'(bus.RegWre), 32'd0);
        check("rst_writereg", 32'(bus.WriteReg), 32'd0);
        check("rst_writedata", bus.WriteData, 32'd0);
        @(negedge clk);
        drive(idle);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(bus.AluReady), 32'd1);

        foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

        // Fill the buffer with two entries behind load returns, then reset mid-cycle
        run_cycle(mk(1,20,'h2020, 0,0,  1,11,'hB1, 20,0, 0,0,0, 0,0,0), 1'b0);
        run_cycle(mk(1,21,'h2121, 1,15, 1,12,'hB2, 20,21, 0,0,0, 0,0,0), 1'b0);
        check("pre_rst_full", 32'(bus.AluReady), 32'd0);
        @(negedge clk);
        drive(mk(1,22,'h2222, 0,0, 1,13,'hB3, 20,15, 0,0,0, 0,0,0));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_regwre", 32'(bus.RegWre), 32'd0);
        check("mid_rst_ready", 32'(bus.AluReady), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("hold_rst_regwre", 32'(bus.RegWre), 32'd0);
        @(negedge clk);
        drive(mk(0,0,0, 0,0, 0,0,0, 20,15, 0,0,0, 0,0,0));
        rst = 1'b0;
        model_reset();
        #1;
        check("post_rst_busy1", 32'(bus.Busy1), 32'd0);
        check("post_rst_busy2", 32'(bus.Busy2), 32'd0);
        check("post_rst_ready", 32'(bus.AluReady), 32'd1);
        repeat (3) run_cycle(mk(0,0,0, 0,0, 0,0,0, 21,20, 0,0,0, 0,0,0), 1'b0);

        // Random traffic over a small register range to force collisions
        for (int n = 0; n < 1500; n++) begin
            vec_t v;
            v = mk($urandom_range(0,1), $urandom_range(0,7), $urandom,
                   ($urandom_range(0,3) == 0), $urandom_range(0,7),
                   ($urandom_range(0,2) == 0), $urandom_range(0,7), $urandom,
                   $urandom_range(0,7), $urandom_range(0,7),
                   0,0,0, 0,0,0);
            run_cycle(v, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Write-side initiator for the register file. Merges two result producers into the single RF write port (RegWre/WriteReg/WriteData):
  - single-cycle ALU results, buffered in a small FIFO;
  - out-of-order load returns from data memory.
- Keeps a pending-load scoreboard and buffered-write tracking so the decode stage can stall on rs/rt hazards.
- Sits between execute/memory stages and the RF write inputs.

Parameters:
FIFO_DEPTH, 2, ALU result buffer entries (power of two, >=2)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
AluValid  in  1  ALU result offered
AluReg  in  ADDR_W  ALU destination register
AluData  in  DATA_W  ALU result
AluReady  out  1  ALU result accepted this cycle if AluValid
LoadIssue  in  1  load issued to memory, destination becomes pending
LoadIssueReg  in  ADDR_W  destination of issued load
LoadValid  in  1  load data returning (always accepted)
LoadReg  in  ADDR_W  destination of returning load
LoadData  in  DATA_W  returned load data
QueryReg1  in  ADDR_W  rs address from decode
QueryReg2  in  ADDR_W  rt address from decode
Busy1  out  1  QueryReg1 has an outstanding or unretired write
Busy2  out  1  QueryReg2 has an outstanding or unretired write
RegWre  out  1  RF write enable, registered
WriteReg  out  ADDR_W  RF write address, registered
WriteData  out  DATA_W  RF write data, registered

Behaviour:
- Reset, asynchronous:
  - RegWre=0, WriteReg=0, WriteData=0.
  - FIFO empty, pending vector all 0.
  - Inputs are ignored while Reset=1. AluReady=1 after deassertion.
- AluReady = (FIFO count < FIFO_DEPTH). It is a function of registered count only, so no full-FIFO enqueue+dequeue in the same cycle. ALU transfer = AluValid && AluReady.
- Register 0 writes, from either source, are accepted and dropped: never queued, never emitted, never pending.
- Output selection each cycle, with priority load > FIFO head > ALU bypass. The result is registered onto RegWre/WriteReg/WriteData at the next edge (latency 1):
  1. LoadValid && LoadReg!=0: emit the load. The FIFO holds, and an accepted ALU result is enqueued.
  2. Else, FIFO non-empty: pop the head and emit it. An accepted ALU result is enqueued, so simultaneous push+pop keeps count.
  3. Else, ALU transfer with AluReg!=0 and FIFO empty: bypass, emit directly. Not enqueued.
  4. Else: RegWre=0. WriteReg/WriteData hold their previous values.
- ALU results retire in acceptance order. Load data never waits.
- Scoreboard pending[31:0]:
  - LoadIssue sets pending[LoadIssueReg], except for reg 0.
  - LoadValid clears pending[LoadReg].
  - Same reg issued and returned in the same cycle: set wins.
  - LoadValid to a non-pending reg is still written; pending stays 0.
- BusyN (combinational) is 1 when QueryRegN!=0 and any of the following holds:
  - pending[QueryRegN];
  - any valid FIFO entry has that reg;
  - RegWre && WriteReg==QueryRegN.
  The RF latches at the end of that cycle, so an RF read in that same cycle is stale.
- Ordering between ALU and load writes to the same reg is not arbitrated here. Decode must stall on Busy before issuing a second producer to a busy reg.
- FIFO pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- Reset mid-operation discards queued and pending state. No write is emitted after Reset rises.

Test Plan:
- Reset, then ALU bypass: AluValid=1, AluReg=3, AluData=0x11 with load idle -> next cycle RegWre=1, WriteReg=3, WriteData=0x11; the cycle after, RegWre=0; FIFO stays empty.
- Load/ALU collision: LoadValid (reg 5, 0xAA) and AluValid (reg 6, 0xBB) in the same cycle -> cycle+1 writes r5=0xAA, cycle+2 writes r6=0xBB.
- FIFO full and backpressure:
  - Hold LoadValid for 4 cycles while presenting ALU results r7, r8, r9.
  - AluReady drops after 2 accepts; r9 is held by the producer.
  - After load traffic ends, writes appear in order r7, r8, r9.
- Scoreboard: LoadIssue r10 -> Busy1=1 for QueryReg1=10. LoadValid r10 -> write emitted next cycle; Busy1 stays 1 through the RegWre cycle, then 0.
- Register 0 and same-cycle issue/return: AluReg=0 -> no RegWre, Busy for 0 always 0. LoadIssue r4 together with LoadValid r4 -> r4 written and pending[4] remains 1.
- Async reset mid-stream: assert Reset with FIFO holding 2 entries -> RegWre=0 immediately, no further writes, AluReady=1, Busy1/2=0 after release.
